// File: rtl/axi_ux_resp_arb.sv
// Round-robin response arbiter: collects per-tile AXI responses and forwards
// one per cycle through a single registered output entry, tagging the source tile.
module axi_ux_resp_arb #(
    parameter int BW        = 32,
    parameter int ADDR_TILE = 4,
    parameter int TILES     = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [TILES-1:0]      tile_AXI_VALID,
    input  logic [2*TILES-1:0]    tile_AXI_RESP,
    input  logic [BW*TILES-1:0]   tile_AXI_DATA,
    output logic [TILES-1:0]      tile_AXI_READY,
    input  logic                  AXI_READY,
    output logic                  AXI_VALID,
    output logic [1:0]            AXI_RESP,
    output logic [BW-1:0]         AXI_DATA,
    output logic [ADDR_TILE-1:0]  AXI_SRC
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t               state;
    logic [ADDR_TILE-1:0] last;
    logic [ADDR_TILE-1:0] winner;
    logic [ADDR_TILE-1:0] cand;
    logic                 found;
    logic                 can_accept;
    logic                 grant;

    // Search last+1 .. last+TILES modulo TILES; the final candidate is last itself,
    // so a lone valid tile wins regardless of where the pointer sits.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= TILES; k++) begin
            cand = ADDR_TILE'((int'(last) + k) % TILES);
            if (!found && tile_AXI_VALID[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Accept when the entry is empty or is being drained in this same cycle.
    assign can_accept     = (state == EMPTY) || AXI_READY;
    assign grant          = can_accept && found && !RST;
    assign tile_AXI_READY = grant ? (TILES'(1) << winner) : '0;
    assign AXI_VALID      = (state == FULL);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= EMPTY;
            AXI_RESP <= 2'b00;
            AXI_DATA <= '0;
            AXI_SRC  <= '0;
            last     <= ADDR_TILE'(TILES - 1);
        end else if (grant) begin
            state    <= FULL;
            AXI_RESP <= tile_AXI_RESP[int'(winner)*2 +: 2];
            AXI_DATA <= tile_AXI_DATA[int'(winner)*BW +: BW];
            AXI_SRC  <= winner;
            last     <= winner;
        end else if (AXI_READY) begin
            state <= EMPTY;
        end
    end

endmodule
